// File: rtl/data_mem_unit.sv
// Byte-addressed unified memory with a fetch port and a data port, arbitrated
// round-robin, serving one access at a time after a fixed LATENCY.
module data_mem_unit #(
  parameter int ADDR_W  = 19,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [31:0]       f_data,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              busy
);
  localparam int       DEPTH    = 2**ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY-1);
  localparam int       NLANE    = 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                sel_f_q, sel_f_d;
  logic                last_f_q, last_f_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [31:0]         f_data_q;
  logic                f_err_q;
  logic [63:0]         d_rdata_q;
  logic                d_err_q;

  logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

  logic                do_access;
  logic [3:0]          nbytes;
  logic [2:0]          amask;
  logic [ADDR_W:0]     end_addr;
  logic                acc_err;
  logic [NLANE-1:0][7:0] rd_lane;

  assign do_access = (state_q == WAIT) && (cnt_q == 4'd0);
  assign nbytes    = 4'd1 << size_q;
  assign amask     = 3'(nbytes - 4'd1);
  assign end_addr  = {1'b0, addr_q} + (ADDR_W+1)'(nbytes);
  assign acc_err   = (|(addr_q[2:0] & amask)) || (end_addr > (ADDR_W+1)'(DEPTH));

  // Lanes beyond the access size read as zero, giving zero extension for free.
  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    assign rd_lane[g] = (4'(g) < nbytes) ? mem_q[addr_q + ADDR_W'(g)] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (do_access && we_q && !acc_err) begin
      for (int i = 0; i < NLANE; i++) begin
        if (4'(i) < nbytes) mem_q[addr_q + ADDR_W'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_f_d  = sel_f_q;
    last_f_d = last_f_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          // Fetch wins only when alone or when data was granted last.
          sel_f_d  = f_req && (!d_req || !last_f_q);
          last_f_d = sel_f_d;
          if (sel_f_d) begin
            addr_d  = f_addr;
            size_d  = 2'd2;
            we_d    = 1'b0;
            wdata_d = 64'h0;
          end else begin
            addr_d  = d_addr;
            size_d  = d_size;
            we_d    = d_we;
            wdata_d = d_wdata;
          end
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sel_f_q   <= 1'b0;
      last_f_q  <= 1'b1;
      addr_q    <= '0;
      size_q    <= 2'd0;
      we_q      <= 1'b0;
      wdata_q   <= 64'h0;
      f_data_q  <= 32'h0;
      f_err_q   <= 1'b0;
      d_rdata_q <= 64'h0;
      d_err_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_f_q  <= sel_f_d;
      last_f_q <= last_f_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      if (do_access) begin
        if (sel_f_q) begin
          f_data_q <= acc_err ? 32'h0 : rd_lane[3:0];
          f_err_q  <= acc_err;
        end else begin
          d_rdata_q <= (acc_err || we_q) ? 64'h0 : rd_lane;
          d_err_q   <= acc_err;
        end
      end
    end
  end

  assign f_ack   = (state_q == RESP) && sel_f_q;
  assign d_ack   = (state_q == RESP) && !sel_f_q;
  assign busy    = (state_q != IDLE);
  assign f_data  = f_data_q;
  assign f_err   = f_err_q;
  assign d_rdata = d_rdata_q;
  assign d_err   = d_err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed plus randomized checks of data_mem_unit against a byte-array model.
module tb_data_mem_unit;
  localparam int ADDR_W = 19;
  localparam int L      = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk, reset;
  logic              f_req, f_ack, f_err;
  logic [ADDR_W-1:0] f_addr;
  logic [31:0]       f_data;
  logic              d_req, d_we, d_ack, d_err, busy;
  logic [1:0]        d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata, d_rdata;

  data_mem_unit #(.ADDR_W(ADDR_W), .LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Reference state: byte memory, arbitration history, last reported outputs.
  logic [7:0]  rm [int];
  bit          lastg_f = 1'b1;
  logic [63:0] last_drd = 64'h0;
  bit          drd_known = 1'b1;
  bit          last_derr = 1'b0;
  logic [31:0] last_fd = 32'h0;
  bit          last_ferr = 1'b0;

  function automatic logic [63:0] ref_rd(int a, int nb);
    logic [63:0] r = 64'h0;
    for (int i = 0; i < nb; i++)
      if (rm.exists(a+i)) r |= 64'(rm[a+i]) << (8*i);
    return r;
  endfunction

  function automatic bit ref_err(int a, int nb);
    return ((a % nb) != 0) || (a + nb > DEPTH);
  endfunction

  task automatic issue(input bit dv, input bit dwe, input int dsz, input int daddr,
                       input logic [63:0] dwd, input bit fv, input int faddr);
    bit d_first, f_first, d_pend, f_pend, e_ok;
    int e, busy_n, nb;
    logic [63:0] exp;
    d_first = dv && (!fv || lastg_f);
    f_first = fv && !d_first;
    d_pend = dv; f_pend = fv; e = 0; busy_n = 0;
    @(negedge clk);
    d_req = dv; d_we = dwe; d_size = 2'(dsz); d_addr = ADDR_W'(daddr); d_wdata = dwd;
    f_req = fv; f_addr = ADDR_W'(faddr);
    while ((d_pend || f_pend) && e < 60) begin
      @(posedge clk); #1; e++;
      if (busy) busy_n++;
      if (d_ack && f_ack) chk("both_ack", 1, 0);
      if (d_ack) begin
        nb = 1 << dsz;
        e_ok = ref_err(daddr, nb);
        exp = (e_ok || dwe) ? 64'h0 : ref_rd(daddr, nb);
        chk("d_lat", 64'(e), 64'(d_first ? L+1 : 2*L+3));
        chk("d_err", 64'(d_err), 64'(e_ok));
        if (!dwe) chk("d_rdata", d_rdata, exp);
        if (dwe && !e_ok)
          for (int i = 0; i < nb; i++) rm[daddr+i] = dwd[8*i +: 8];
        last_derr = e_ok; drd_known = !dwe; last_drd = exp;
        d_req = 1'b0; d_pend = 1'b0;
      end
      if (f_ack) begin
        e_ok = ref_err(faddr, 4);
        exp = e_ok ? 64'h0 : ref_rd(faddr, 4);
        chk("f_lat", 64'(e), 64'(f_first ? L+1 : 2*L+3));
        chk("f_err", 64'(f_err), 64'(e_ok));
        chk("f_data", 64'(f_data), exp);
        last_ferr = e_ok; last_fd = exp[31:0];
        f_req = 1'b0; f_pend = 1'b0;
      end
    end
    if (d_pend) begin chk("d_timeout", 1, 0); d_req = 1'b0; end
    if (f_pend) begin chk("f_timeout", 1, 0); f_req = 1'b0; end
    chk("busy_cycles", 64'(busy_n), 64'((L+1) * (int'(dv) + int'(fv))));
    if (dv && fv) lastg_f = d_first;
    else if (dv)  lastg_f = 1'b0;
    else if (fv)  lastg_f = 1'b1;
    @(posedge clk); #1;
    chk("ack_one_cycle", {62'h0, d_ack, f_ack}, 64'h0);
    chk("busy_end", 64'(busy), 64'h0);
    if (!dv && drd_known) chk("d_hold", d_rdata, last_drd);
    if (!dv) chk("d_err_hold", 64'(d_err), 64'(last_derr));
    if (!fv) chk("f_hold", {31'h0, f_err, f_data}, {31'h0, last_ferr, last_fd});
  endtask

  function automatic int pick_addr();
    return ($urandom_range(0, 1) ? 'h7FFF0 : 'h300) + int'($urandom_range(0, 15));
  endfunction

  initial begin
    int acks;
    reset = 1'b1; f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_size = 0;
    d_addr = '0; d_wdata = 64'h0;
    #3;
    chk("rst_outputs", {60'h0, f_ack, d_ack, f_err, d_err}, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_data", {f_data, d_rdata[31:0]} | 64'(d_rdata[63:32]), 64'h0);
    @(negedge clk); @(negedge clk); reset = 1'b0;

    issue(1, 1, 3, 'h100, 64'h1122334455667788, 0, 0);
    issue(1, 0, 3, 'h100, 64'h0, 0, 0);
    chk("ld8_const", d_rdata, 64'h1122334455667788);
    issue(1, 0, 0, 'h101, 64'h0, 0, 0);
    chk("ld1_const", d_rdata, 64'h77);
    issue(1, 0, 1, 'h106, 64'h0, 0, 0);
    chk("ld2_const", d_rdata, 64'h1122);
    issue(1, 1, 2, 'h102, 64'h0000_0000_CAFE_F00D, 0, 0);
    chk("st_misalign_err", 64'(d_err), 64'h1);
    issue(1, 0, 3, 'h100, 64'h0, 0, 0);
    chk("ld8_after_err", d_rdata, 64'h1122334455667788);
    issue(1, 1, 2, 'h2000, 64'h0000_0000_DEAD_BEEF, 0, 0);
    issue(1, 0, 3, 'h100, 64'h0, 1, 'h2000);
    chk("fetch_const", 64'(f_data), 64'hDEADBEEF);
    issue(1, 0, 3, 'h100, 64'h0, 1, 'h2000);

    // Abandon a store mid-flight with reset.
    @(negedge clk);
    d_req = 1; d_we = 1; d_size = 2'd3; d_addr = ADDR_W'('h200); d_wdata = 64'hFF;
    @(posedge clk); #1;
    chk("st_busy", 64'(busy), 64'h1);
    #3; reset = 1'b1; d_req = 1'b0; #1;
    chk("rst_wait_busy", 64'(busy), 64'h0);
    chk("rst_wait_ack", {62'h0, d_ack, f_ack}, 64'h0);
    chk("rst_wait_data", d_rdata | 64'(f_data), 64'h0);
    lastg_f = 1'b1; last_drd = 64'h0; drd_known = 1'b1; last_derr = 1'b0;
    last_fd = 32'h0; last_ferr = 1'b0;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      acks += int'(d_ack) + int'(f_ack);
    end
    chk("no_ack_after_rst", 64'(acks), 64'h0);
    issue(1, 0, 3, 'h200, 64'h0, 0, 0);
    chk("abandoned_store", d_rdata, 64'h0);

    issue(1, 0, 3, 'h7FFFC, 64'h0, 0, 0);
    chk("ld_end_err", {d_rdata[62:0], d_err}, 64'h1);
    issue(0, 0, 0, 0, 64'h0, 1, 'h2002);
    chk("f_misalign_err", {31'h0, f_err, f_data}, 64'h1_0000_0000);
    issue(0, 0, 0, 0, 64'h0, 1, 'h7FFFC);
    issue(1, 0, 3, 'h7FFF8, 64'h0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = int'($urandom_range(0, 3));
      issue(kind != 1, kind == 0 || kind == 3 ? bit'($urandom_range(0, 1)) : 1'b0,
            int'($urandom_range(0, 3)), pick_addr(), {$urandom, $urandom},
            kind >= 1 && kind != 3 ? 1'b1 : (kind == 3 ? bit'($urandom_range(0, 1)) : 1'b0),
            pick_addr() & ~int'($urandom_range(0, 1) ? 0 : 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
